decodificador_varredura: RTL

//  Parametrised, registered N-to-2^N one-hot decoder with two modes: direct

---
 rtl/decodificador_varredura_if.sv | 26 ++
 rtl/decodificador_varredura.sv | 98 +++++++++
 2 files changed

// File: rtl/decodificador_varredura_if.sv
// Bus bundle for the scanning one-hot decoder: control/index inputs and the
// registered one-hot outputs. The controller side uses "master", the decoder
// uses "slave".
interface decodificador_varredura_if #(
    parameter int N_BITS = 3
);
    localparam int OUT_W = 2 ** N_BITS;

    logic              en;
    logic              modo;
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] ultimo;
    logic [OUT_W-1:0]  s;
    logic [N_BITS-1:0] idx;
    logic              fim_ciclo;

    modport master (
        output en, modo, a, ultimo,
        input  s, idx, fim_ciclo
    );

    modport slave (
        input  en, modo, a, ultimo,
        output s, idx, fim_ciclo
    );
endinterface

// File: rtl/decodificador_varredura.sv
// Registered N-to-2^N one-hot decoder with two modes: direct decode of a
// binary index, or an autonomous scan that walks the active output through
// 0..ultimo at a prescaled rate. Typical load: display anodes, row strobes,
// chip selects.
module decodificador_varredura #(
    parameter int N_BITS      = 3,
    parameter int PRESC       = 4,
    parameter int ATIVO_BAIXO = 0
) (
    input logic                clk,
    input logic                rst_n,
    decodificador_varredura_if.slave bus
);
    localparam int OUT_W   = 2 ** N_BITS;
    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC - 1);
    localparam logic [OUT_W-1:0]   INATIVO   =
        (ATIVO_BAIXO != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    // The registered copy of "modo" is the only mode state; leaving direct
    // mode for scan is what restarts the sequence from index 0.
    typedef enum logic {
        MODO_DIRETO    = 1'b0,
        MODO_VARREDURA = 1'b1
    } modo_t;

    modo_t              modo_q, modo_d;
    logic [N_BITS-1:0]  idx_q, idx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [OUT_W-1:0]   s_q, s_d;
    logic               fim_q, fim_d;

    // One active bit at position k, inverted as a whole for active-low loads.
    function automatic logic [OUT_W-1:0] codifica(input logic [N_BITS-1:0] k);
        logic [OUT_W-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        return oh ^ INATIVO;
    endfunction

    // State register: everything, outputs included, is registered here so no
    // input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modo_q  <= MODO_DIRETO;
            idx_q   <= '0;
            presc_q <= '0;
            s_q     <= INATIVO;
            fim_q   <= 1'b0;
        end else begin
            modo_q  <= modo_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            s_q     <= s_d;
            fim_q   <= fim_d;
        end
    end

    // Next-state logic. With en low everything holds and the outputs go
    // inactive; a scan-mode entry wins over stepping, and a step past
    // "ultimo" (including ultimo lowered below idx) wraps to 0 with a pulse.
    always_comb begin
        modo_d  = modo_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        s_d     = INATIVO;
        fim_d   = 1'b0;
        if (bus.en) begin
            if (bus.modo) begin
                modo_d = MODO_VARREDURA;
                if (modo_q == MODO_DIRETO) begin
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (idx_q >= bus.ultimo) begin
                        idx_d = '0;
                        fim_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end else begin
                modo_d  = MODO_DIRETO;
                idx_d   = bus.a;
                presc_d = '0;
            end
            s_d = codifica(idx_d);
        end
    end

    assign bus.s         = s_q;
    assign bus.idx       = idx_q;
    assign bus.fim_ciclo = fim_q;

endmodule
